// File: rtl/global_buffer_sequencer_if.sv
// Bundle of the instruction, host-data and buffer-port signals that surround
// the global buffer sequencer. The sequencer uses the slave modport; whoever
// issues instructions, streams host data and models the buffer uses master.
//
// Handshakes:
//   - An instruction transfers on a cycle with instr_valid_i && instr_ready_o.
//   - A host write beat transfers on a cycle with wr_valid_i && wr_ready_o.
//   - Neither valid may depend on its ready.
//   - Read beats (rd_valid_o) and buffer read data (buf_rd_data_valid_i)
//     have no ready: the receiver must take them in the cycle they appear.
interface global_buffer_sequencer_if #(
  parameter int addrWidth      = 32,
  parameter int dataSize       = 8,
  parameter int interfaceDepth = 16,
  parameter int countWidth     = 16
);
  localparam int W = interfaceDepth * dataSize;

  // instruction channel
  logic [3:0]            instr_i;
  logic [countWidth-1:0] instr_count_i;
  logic                  instr_valid_i;
  logic                  instr_ready_o;

  // region bases
  logic [addrWidth-1:0]  weight_start_addr_i;
  logic [addrWidth-1:0]  activation_start_addr_i;
  logic [addrWidth-1:0]  output_start_addr_i;

  // host write stream
  logic [W-1:0]          wr_data_i;
  logic                  wr_valid_i;
  logic                  wr_ready_o;

  // buffer data port
  logic [addrWidth-1:0]  buf_addr_o;
  logic                  buf_wr_en_o;
  logic [W-1:0]          buf_wr_data_o;
  logic                  buf_rd_en_o;
  logic [W-1:0]          buf_rd_data_i;
  logic                  buf_rd_data_valid_i;

  // host read stream and status
  logic [W-1:0]          rd_data_o;
  logic                  rd_valid_o;
  logic                  busy_o;
  logic                  done_o;

  modport slave (
    input  instr_i, instr_count_i, instr_valid_i,
    input  weight_start_addr_i, activation_start_addr_i, output_start_addr_i,
    input  wr_data_i, wr_valid_i,
    input  buf_rd_data_i, buf_rd_data_valid_i,
    output instr_ready_o, wr_ready_o,
    output buf_addr_o, buf_wr_en_o, buf_wr_data_o, buf_rd_en_o,
    output rd_data_o, rd_valid_o, busy_o, done_o
  );

  modport master (
    output instr_i, instr_count_i, instr_valid_i,
    output weight_start_addr_i, activation_start_addr_i, output_start_addr_i,
    output wr_data_i, wr_valid_i,
    output buf_rd_data_i, buf_rd_data_valid_i,
    input  instr_ready_o, wr_ready_o,
    input  buf_addr_o, buf_wr_en_o, buf_wr_data_o, buf_rd_en_o,
    input  rd_data_o, rd_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/global_buffer_sequencer.sv
// Global buffer sequencer: takes one opcode plus beat count at a time, keeps
// the weight/activation/output pointers, and turns each data instruction into
// a run of per-beat buffer writes (from the host) or reads (back to the host).
// The FSM state is exported on dbg_state_o for checkers.
module global_buffer_sequencer #(
  parameter int addrWidth      = 32,
  parameter int dataSize       = 8,
  parameter int interfaceDepth = 16,
  parameter int countWidth     = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  global_buffer_sequencer_if.slave bus,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [3:0] {
    I_NOP             = 4'd0,
    I_POINTER_RESET   = 4'd1,
    I_LOAD_WEIGHT     = 4'd2,
    I_LOAD_ACTIVATION = 4'd3,
    I_LOAD_OUTPUT     = 4'd4,
    I_READ_ACTIVATION = 4'd5
  } global_buffer_instruction_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [addrWidth-1:0]  ADDR_ONE = addrWidth'(1);
  localparam logic [countWidth-1:0] CNT_ONE  = countWidth'(1);

  state_t                  state_q;
  logic [3:0]              op_q;
  logic [countWidth-1:0]   count_q;
  logic [countWidth-1:0]   beat_cnt_q;
  logic [countWidth-1:0]   resp_cnt_q;
  logic [addrWidth-1:0]    wptr_q;
  logic [addrWidth-1:0]    aptr_q;
  logic [addrWidth-1:0]    optr_q;
  logic [addrWidth-1:0]    addr_hold_q;
  logic                    done_q;

  logic [addrWidth-1:0]    sel_ptr;
  logic [addrWidth-1:0]    sel_ptr_d;
  logic [countWidth-1:0]   beat_cnt_d;
  logic [countWidth-1:0]   resp_cnt_d;
  logic                    wr_fire;
  logic                    rsp_fire;
  logic                    in_read_phase;

  // Pointer used by the current instruction; reads always use the activation pointer.
  always_comb begin
    sel_ptr = aptr_q;
    case (op_q)
      I_LOAD_WEIGHT: sel_ptr = wptr_q;
      I_LOAD_OUTPUT: sel_ptr = optr_q;
      default:       sel_ptr = aptr_q;
    endcase
  end

  assign sel_ptr_d     = sel_ptr + ADDR_ONE;
  assign beat_cnt_d    = beat_cnt_q + CNT_ONE;
  assign resp_cnt_d    = resp_cnt_q + CNT_ONE;
  assign in_read_phase = (state_q == S_READ) || (state_q == S_DRAIN);
  assign wr_fire       = (state_q == S_WRITE) && bus.wr_valid_i;
  assign rsp_fire      = in_read_phase && bus.buf_rd_data_valid_i;

  // Host-facing and buffer-facing outputs; strobes are decoded from the registered state.
  assign bus.instr_ready_o = (state_q == S_IDLE);
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.wr_ready_o    = (state_q == S_WRITE);
  assign bus.buf_wr_en_o   = wr_fire;
  assign bus.buf_wr_data_o = bus.wr_data_i;
  assign bus.buf_rd_en_o   = (state_q == S_READ);
  assign bus.buf_addr_o    = ((state_q == S_WRITE) || (state_q == S_READ)) ? sel_ptr : addr_hold_q;
  assign bus.rd_data_o     = bus.buf_rd_data_i;
  assign bus.rd_valid_o    = rsp_fire;
  assign bus.done_o        = done_q;
  assign dbg_state_o       = state_q;

  // Sequencer FSM: instruction decode, pointer bookkeeping and completion pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      op_q        <= 4'd0;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      resp_cnt_q  <= '0;
      wptr_q      <= '0;
      aptr_q      <= '0;
      optr_q      <= '0;
      addr_hold_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.instr_valid_i) begin
            op_q       <= bus.instr_i;
            count_q    <= bus.instr_count_i;
            beat_cnt_q <= '0;
            resp_cnt_q <= '0;
            case (bus.instr_i)
              I_POINTER_RESET: begin
                wptr_q <= bus.weight_start_addr_i;
                aptr_q <= bus.activation_start_addr_i;
                optr_q <= bus.output_start_addr_i;
                done_q <= 1'b1;
              end
              I_LOAD_WEIGHT, I_LOAD_ACTIVATION, I_LOAD_OUTPUT: begin
                // a zero-beat load touches nothing and completes at once
                if (bus.instr_count_i == '0) done_q <= 1'b1;
                else                         state_q <= S_WRITE;
              end
              I_READ_ACTIVATION: begin
                if (bus.instr_count_i == '0) done_q <= 1'b1;
                else                         state_q <= S_READ;
              end
              default: done_q <= 1'b1;  // NOP and undefined opcodes
            endcase
          end
        end

        S_WRITE: begin
          addr_hold_q <= sel_ptr;
          if (wr_fire) begin
            case (op_q)
              I_LOAD_WEIGHT: wptr_q <= sel_ptr_d;
              I_LOAD_OUTPUT: optr_q <= sel_ptr_d;
              default:       aptr_q <= sel_ptr_d;
            endcase
            beat_cnt_q <= beat_cnt_d;
            if (beat_cnt_d == count_q) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        S_READ: begin
          // one read issued per cycle, no host backpressure
          addr_hold_q <= aptr_q;
          aptr_q      <= aptr_q + ADDR_ONE;
          beat_cnt_q  <= beat_cnt_d;
          if (beat_cnt_d == count_q) state_q <= S_DRAIN;
          // a zero-latency buffer can return the last beat while still issuing
          if (rsp_fire) begin
            resp_cnt_q <= resp_cnt_d;
            if (resp_cnt_d == count_q) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (rsp_fire) begin
            resp_cnt_q <= resp_cnt_d;
            if (resp_cnt_d == count_q) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_global_buffer_sequencer.sv
// Bench for global_buffer_sequencer: directed scenarios followed by random
// instruction streams, scored against a pointer/queue model of the buffer.
module tb_global_buffer_sequencer;
  localparam int AW  = 32;
  localparam int DS  = 8;
  localparam int ID  = 16;
  localparam int CW  = 16;
  localparam int W   = ID * DS;
  localparam int LAT = 2;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PRST = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_LA   = 4'd3;
  localparam logic [3:0] OP_LO   = 4'd4;
  localparam logic [3:0] OP_RA   = 4'd5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_exp_t;

  typedef struct packed {
    logic [31:0]  due;
    logic [W-1:0] data;
  } rsp_t;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] dbg_state;
  int         cyc  = 0;

  int n_checks  = 0;
  int n_fail    = 0;
  int done_seen = 0;
  int done_exp  = 0;
  int last_io_cyc = 0;

  wr_exp_t       exp_wr_q[$];
  logic [AW-1:0] exp_ra_q[$];
  logic [W-1:0]  exp_q[$];
  rsp_t          rsp_q[$];
  logic [W-1:0]  wbeats[$];

  logic [AW-1:0] m_wptr, m_aptr, m_optr;

  global_buffer_sequencer_if #(
    .addrWidth(AW), .dataSize(DS), .interfaceDepth(ID), .countWidth(CW)
  ) bus_if ();

  global_buffer_sequencer #(
    .addrWidth(AW), .dataSize(DS), .interfaceDepth(ID), .countWidth(CW)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus_if),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5678, {a[15:0], a[31:16]}};
  endfunction

  task automatic check(input string tag, input logic [W+AW-1:0] got, input logic [W+AW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- buffer model: fixed latency, in-order ----------------
  always @(negedge clk)
    if (nrst && bus_if.buf_rd_en_o)
      rsp_q.push_back('{due: 32'(cyc + LAT), data: mem_word(bus_if.buf_addr_o)});

  always @(posedge clk) begin
    #1;
    if (!nrst) begin
      rsp_q.delete();
      bus_if.buf_rd_data_valid_i = 1'b0;
    end else if (rsp_q.size() > 0 && rsp_q[0].due == 32'(cyc)) begin
      bus_if.buf_rd_data_valid_i = 1'b1;
      bus_if.buf_rd_data_i       = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      bus_if.buf_rd_data_valid_i = 1'b0;
      bus_if.buf_rd_data_i       = {4{$urandom}};
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (nrst) begin
      if (bus_if.buf_wr_en_o) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", bus_if.buf_wr_en_o, 0);
        else begin
          wr_exp_t e;
          e = exp_wr_q.pop_front();
          check("wr_addr", bus_if.buf_addr_o, e.addr);
          check("wr_data", bus_if.buf_wr_data_o, e.data);
        end
        last_io_cyc = cyc;
      end
      if (bus_if.buf_rd_en_o) begin
        if (exp_ra_q.size() == 0) check("rd_issue_unexpected", bus_if.buf_rd_en_o, 0);
        else check("rd_addr", bus_if.buf_addr_o, exp_ra_q.pop_front());
      end
      if (bus_if.rd_valid_o) begin
        if (exp_q.size() == 0) check("rd_beat_unexpected", bus_if.rd_valid_o, 0);
        else check("rd_data", bus_if.rd_data_o, exp_q.pop_front());
        last_io_cyc = cyc;
      end
      if (bus_if.done_o) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input int cnt, output int acc, output bit ok);
    @(posedge clk); #1;
    bus_if.instr_i       = op;
    bus_if.instr_count_i = CW'(cnt);
    bus_if.instr_valid_i = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus_if.instr_ready_o) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    if (!ok) check("accept_timeout", bus_if.instr_ready_o, 1);
    @(posedge clk); #1;
    bus_if.instr_valid_i = 1'b0;
    bus_if.instr_i       = 4'($urandom);
    bus_if.instr_count_i = CW'($urandom);
  endtask

  // Streams wbeats until stop_at handshakes; vmode 0 = always valid,
  // 1 = fixed pattern 1,0,0,1,1,0,1, 2 = random.
  task automatic drive_writes(input int stop_at, input int vmode);
    int idx = 0;
    int k   = 0;
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    bit v;
    while (idx < stop_at && k < 300) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = pat[k % 7];
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus_if.wr_valid_i = v;
      bus_if.wr_data_i  = v ? wbeats[idx] : {4{$urandom}};
      @(negedge clk);
      check("busy_in_write", bus_if.busy_o, 1);
      if (bus_if.wr_valid_i && bus_if.wr_ready_o) idx++;
      if (idx < stop_at) begin
        @(posedge clk); #1;
      end
      k++;
    end
    if (idx < stop_at) check("write_timeout", 32'(idx), 32'(stop_at));
  endtask

  // Model the instruction, run it, and check when done_o appears.
  task automatic run_instr(input logic [3:0] op, input int cnt, input int vmode);
    int  acc = 0;
    int  done_cyc = 0;
    bit  ok;
    bit  is_wr = (op == OP_LW || op == OP_LA || op == OP_LO);
    bit  is_rd = (op == OP_RA);
    bit  got_done = 1'b0;
    logic [AW-1:0] p;

    if (op == OP_PRST) begin
      m_wptr = bus_if.weight_start_addr_i;
      m_aptr = bus_if.activation_start_addr_i;
      m_optr = bus_if.output_start_addr_i;
    end
    if (is_wr) begin
      p = (op == OP_LW) ? m_wptr : (op == OP_LO) ? m_optr : m_aptr;
      wbeats.delete();
      for (int i = 0; i < cnt; i++) begin
        wbeats.push_back({$urandom, $urandom, $urandom, $urandom});
        exp_wr_q.push_back('{addr: p + AW'(i), data: wbeats[i]});
      end
      if (op == OP_LW)      m_wptr = p + AW'(cnt);
      else if (op == OP_LO) m_optr = p + AW'(cnt);
      else                  m_aptr = p + AW'(cnt);
    end
    if (is_rd) begin
      for (int i = 0; i < cnt; i++) begin
        exp_ra_q.push_back(m_aptr + AW'(i));
        exp_q.push_back(mem_word(m_aptr + AW'(i)));
      end
      m_aptr = m_aptr + AW'(cnt);
    end

    issue(op, cnt, acc, ok);
    if (!ok) return;
    if (is_wr && cnt > 0) begin
      drive_writes(cnt, vmode);
      @(posedge clk); #1;
      bus_if.wr_valid_i = 1'b0;
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus_if.done_o) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (is_rd) check("ready_low_in_read", bus_if.instr_ready_o, 0);
    end
    done_exp++;
    if (!got_done) check("done_timeout", bus_if.done_o, 1);
    else if ((is_wr || is_rd) && cnt > 0) check("done_after_last_beat", 32'(done_cyc), 32'(last_io_cyc + 1));
    else check("done_after_accept", 32'(done_cyc), 32'(acc + 1));
  endtask

  task automatic ptr_reset(input logic [AW-1:0] w, input logic [AW-1:0] a, input logic [AW-1:0] o);
    bus_if.weight_start_addr_i     = w;
    bus_if.activation_start_addr_i = a;
    bus_if.output_start_addr_i     = o;
    run_instr(OP_PRST, $urandom_range(0, 9), 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_instr_ready"}, bus_if.instr_ready_o, 1);
    check({pfx, "_busy"},        bus_if.busy_o, 0);
    check({pfx, "_done"},        bus_if.done_o, 0);
    check({pfx, "_wr_ready"},    bus_if.wr_ready_o, 0);
    check({pfx, "_buf_wr_en"},   bus_if.buf_wr_en_o, 0);
    check({pfx, "_buf_rd_en"},   bus_if.buf_rd_en_o, 0);
    check({pfx, "_rd_valid"},    bus_if.rd_valid_o, 0);
    check({pfx, "_buf_addr"},    bus_if.buf_addr_o, 0);
    check({pfx, "_state"},       dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  acc;
    int  d0;
    bit  ok;
    bus_if.instr_i                 = OP_NOP;
    bus_if.instr_count_i           = '0;
    bus_if.instr_valid_i           = 1'b0;
    bus_if.weight_start_addr_i     = '0;
    bus_if.activation_start_addr_i = '0;
    bus_if.output_start_addr_i     = '0;
    bus_if.wr_data_i               = '0;
    bus_if.wr_valid_i              = 1'b0;
    bus_if.buf_rd_data_i           = '0;
    bus_if.buf_rd_data_valid_i     = 1'b0;
    m_wptr = '0; m_aptr = '0; m_optr = '0;

    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    nrst = 1'b1;

    // pointer reset then a 3-beat weight load
    ptr_reset(32'h100, 32'h200, 32'h300);
    run_instr(OP_LW, 3, 0);
    // activation load with stalls
    run_instr(OP_LA, 4, 1);
    // read with a 2-cycle buffer
    ptr_reset(32'h100, 32'h200, 32'h300);
    run_instr(OP_RA, 5, 0);
    // zero count and undefined opcode leave pointers alone
    run_instr(OP_LO, 0, 0);
    run_instr(4'hF, 3, 0);
    run_instr(OP_RA, 0, 0);
    run_instr(OP_LO, 1, 0);
    run_instr(OP_RA, 1, 0);
    run_instr(OP_LW, 1, 2);
    // output pointer wrap
    ptr_reset(32'h10, 32'h20, 32'hFFFF_FFFF);
    run_instr(OP_LO, 2, 2);
    run_instr(OP_LO, 1, 0);

    // random instruction streams
    for (int it = 0; it < 40; it++) begin
      int r = $urandom_range(0, 9);
      int c = $urandom_range(0, 6);
      case (r)
        0: ptr_reset($urandom_range(0, 1) ? $urandom : 32'hFFFF_FFFF - $urandom_range(0, 3),
                     $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFFF - $urandom_range(0, 3),
                     $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFFF - $urandom_range(0, 3));
        1: run_instr(OP_NOP, c, 0);
        2: run_instr(4'($urandom_range(6, 15)), c, 0);
        3: run_instr(OP_LW, c, 2);
        4: run_instr(OP_LA, c, 2);
        5: run_instr(OP_LO, c, $urandom_range(0, 2));
        default: run_instr(OP_RA, c, 0);
      endcase
    end

    // asynchronous reset after 2 of 8 write beats
    ptr_reset(32'h40, 32'h50, 32'h60);
    wbeats.delete();
    for (int i = 0; i < 8; i++) begin
      wbeats.push_back({$urandom, $urandom, $urandom, $urandom});
      exp_wr_q.push_back('{addr: 32'h40 + AW'(i), data: wbeats[i]});
    end
    issue(OP_LW, 8, acc, ok);
    if (ok) drive_writes(2, 0);
    @(posedge clk); #1;
    bus_if.wr_valid_i = 1'b1;
    nrst = 1'b0;
    d0 = done_seen;
    #1;
    check("midrst_busy",      bus_if.busy_o, 0);
    check("midrst_wr_ready",  bus_if.wr_ready_o, 0);
    check("midrst_buf_wr_en", bus_if.buf_wr_en_o, 0);
    check("midrst_buf_addr",  bus_if.buf_addr_o, 0);
    check("midrst_done",      bus_if.done_o, 0);
    check("midrst_rd_valid",  bus_if.rd_valid_o, 0);
    exp_wr_q.delete();
    m_wptr = '0; m_aptr = '0; m_optr = '0;
    repeat (2) @(posedge clk);
    #3;
    nrst = 1'b1;
    bus_if.wr_valid_i = 1'b0;
    @(negedge clk);
    check("postrst_instr_ready", bus_if.instr_ready_o, 1);
    check("postrst_busy", bus_if.busy_o, 0);
    repeat (3) @(negedge clk);
    check("postrst_no_done", 32'(done_seen), 32'(d0));
    run_instr(OP_LW, 2, 0);
    run_instr(OP_RA, 2, 0);
    run_instr(OP_LO, 1, 0);

    repeat (5) @(negedge clk);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 0);
    check("rd_addr_queue_drained", 32'(exp_ra_q.size()), 0);
    check("rd_data_queue_drained", 32'(exp_q.size()), 0);
    check("done_pulse_count", 32'(done_seen), 32'(done_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hard stop in case a handshake wedges beyond every local bound
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
